mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 16-bit-address, 32-bit-data memory port between two requesters:
  - the instruction-fetch path, which issues fetch addresses from the program counter;
  - the data path, which performs load/store.
- Sits between the processor controller/datapath and the memory/MMU.
- Fixed data-over-fetch priority, with a starvation guard for fetch.
- Tracks in-flight reads so each read result returns only to the requester that issued it.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 32, memory data width.
- RD_LAT, 1, memory read latency in cycles (legal range 1..4).
- STARVE_MAX, 3, consecutive data wins allowed while fetch waits (legal range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  when 1, no new grants; in-flight reads still complete.
- if_req  input  1  fetch read request; must be held until if_gnt.
- if_addr  input  ADDR_W  fetch address; stable while if_req=1.
- if_gnt  output  1  fetch request accepted this cycle (combinational).
- if_rvalid  output  1  fetch read data valid (registered).
- if_rdata  output  DATA_W  fetch read data (registered).
- d_req  input  1  data request; must be held until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_gnt  output  1  data request accepted this cycle (combinational).
- d_rvalid  output  1  data read data valid (registered).
- d_rdata  output  DATA_W  data read data (registered).
- mem_en  output  1  memory access this cycle.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after the mem_en cycle.
- busy  output  1  1 while any read is in flight.

Behaviour:
- Reset: synchronous on clk, active-high. Clears the starvation counter, tag pipeline, if_rvalid/d_rvalid and if_rdata/d_rdata (to 0).
  - While reset=1: no grants; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reads in flight when reset asserts are dropped; no rvalid ever appears for them.
- Arbitration (combinational, each cycle, when reset=0 and stall=0):
  - d_req only -> data granted.
  - if_req only -> fetch granted.
  - Both -> data granted unless starve_cnt == STARVE_MAX, in which case fetch granted.
  - At most one grant per cycle.
  - Grant drives mem_en=1, mem_addr = winner address, mem_we = d_we for data (0 for fetch), mem_wdata = d_wdata for data (0 otherwise).
  - No grant -> mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Starvation counter (4 bits, registered):
  - Increments when if_req=1 and data is granted.
  - Clears when fetch is granted or if_req=0.
  - Holds during stall.
  - Saturates at STARVE_MAX.
- Read tag pipeline: RD_LAT stages of {valid, is_fetch}.
  - Stage 0 loads {1,1} on a fetch grant, {1,0} on a data read grant, {0,x} otherwise; writes carry no tag.
  - At the tail, mem_rdata is registered into the selected requester's rdata, and its rvalid pulses for exactly one cycle.
  - Total read latency: grant in cycle N -> rvalid in cycle N+RD_LAT+1.
  - rdata holds its last value until the next read for that requester.
- Back-to-back grants are allowed every cycle; the pipeline accepts one new tag per cycle and never stalls.
- stall: blocks new grants only; the pipeline drains normally.
- busy = OR of all pipeline valid bits.
- Writes: complete in the grant cycle; no response is generated.
- A requester that drops req before its grant is a protocol violation; the arbiter does not check for it.

Decomposition:
- Shared package (def include):
  - tag constants TAG_FETCH=1, TAG_DATA=0;
  - STARVE_MAX and RD_LAT defaults;
  - ADDR_W/DATA_W widths matching the controller's memaddr/memdata.
- One natural sub-module: rd_tag_pipe (parameterised RD_LAT shift register of {valid, tag}, with synchronous clear).

Test Plan:
- Fetch only, RD_LAT=1: if_req=1, if_addr=0x0010 in cycle 0.
  - Required: if_gnt=1 and mem_addr=0x0010 in cycle 0.
  - Memory returns 0xDEADBEEF in cycle 1 -> if_rvalid=1, if_rdata=0xDEADBEEF in cycle 2; d_rvalid stays 0.
- Contention, STARVE_MAX=3: if_req and d_req (reads) held continuously.
  - Required grant sequence: D, D, D, F, D, D, D, F...
  - starve_cnt observed 0,1,2,3,0.
- Data write: d_req=1, d_we=1, d_addr=0x0100, d_wdata=0x12345678.
  - Required: mem_en=1, mem_we=1 with those values in the same cycle; no rvalid afterwards.
- Interleaved reads, RD_LAT=3: back-to-back grants F(0x0001), D(0x0200), F(0x0002).
  - Required: rvalid pulses arrive in cycles 4, 5, 6 on if, d, if respectively, each paired with its memory data.
- Stall: stall=1 for 3 cycles with both requests pending and one read in flight.
  - Required: no gnt and mem_en=0 during stall; the in-flight rvalid still appears; starve_cnt unchanged.
- Reset mid-read, RD_LAT=2: reset=1 one cycle after a data read grant.
  - Required: d_rvalid never asserts for that read; busy=0 and all rdata=0 the cycle after reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory port arbiter.
package mem_port_arbiter_pkg;

    // Widths match the controller's memaddr/memdata buses.
    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 32;

    // Memory read latency and fetch starvation limit defaults.
    localparam int RD_LAT_DEF     = 1;
    localparam int STARVE_MAX_DEF = 3;
    localparam int STARVE_W       = 4;

    // Read tag identifying which requester owns an in-flight read.
    localparam logic TAG_FETCH = 1'b1;
    localparam logic TAG_DATA  = 1'b0;

    // Winner of the memory port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Shift register of {valid, tag} that follows each read through the memory
// latency so the returning data can be steered to its requester.
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid_i,
    input  logic in_tag_i,
    output logic out_valid_o,
    output logic out_tag_o,
    output logic any_valid_o
);

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [RD_LAT-1:0] tag_q, tag_d;

    // Next stage contents: new tag enters stage 0, everything else moves one stage.
    always_comb begin
        valid_d    = '0;
        tag_d      = '0;
        valid_d[0] = in_valid_i;
        tag_d[0]   = in_valid_i ? in_tag_i : TAG_DATA;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid_o = valid_q[RD_LAT-1];
    assign out_tag_o   = tag_q[RD_LAT-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: data path beats fetch,
// except when fetch has lost STARVE_MAX times in a row.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    gnt_e              winner;
    logic              starved;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic              tail_valid;
    logic              tail_tag;
    logic              pipe_busy;

    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    assign starved = (starve_cnt_q == STARVE_LIM);

    // Pick the winner: data first unless fetch has been starved too long.
    always_comb begin
        winner = GNT_NONE;
        if (!reset && !stall) begin
            if (d_req && !(if_req && starved)) begin
                winner = GNT_DATA;
            end else if (if_req) begin
                winner = GNT_FETCH;
            end
        end
    end

    assign if_gnt    = (winner == GNT_FETCH);
    assign d_gnt     = (winner == GNT_DATA);
    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    // Count consecutive data wins over a waiting fetch; frozen while stalled.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!stall) begin
            if (if_gnt || !if_req) begin
                starve_cnt_d = '0;
            end else if (d_gnt && !starved) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (if_gnt | (d_gnt & ~d_we)),
        .in_tag_i    (if_gnt ? TAG_FETCH : TAG_DATA),
        .out_valid_o (tail_valid),
        .out_tag_o   (tail_tag),
        .any_valid_o (pipe_busy)
    );

    // Steer returning read data to the owner of the tag at the pipe tail.
    always_comb begin
        if_rvalid_d = tail_valid && (tail_tag == TAG_FETCH);
        d_rvalid_d  = tail_valid && (tail_tag == TAG_DATA);
        if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
        d_rdata_d   = d_rvalid_d ? mem_rdata : d_rdata_q;
    end

    // Response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = pipe_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RD_LAT = 1, 2, 3) share one stimulus stream,
// each with its own memory model returning data RD_LAT cycles after a read.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt    [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata  [NI];
    logic        d_gnt     [NI];
    logic        d_rvalid  [NI];
    logic [31:0] d_rdata   [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [15:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] memfn(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
    endfunction

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            logic [31:0] mq [k+1];

            always @(posedge clk) begin
                mq[0] <= (mem_en[k] && !mem_we[k]) ? memfn(mem_addr[k]) : 32'h0;
                for (int i = 1; i <= k; i++) mq[i] <= mq[i-1];
            end
            assign mem_rdata[k] = mq[k];

            mem_port_arbiter #(
                .ADDR_W     (16),
                .DATA_W     (32),
                .RD_LAT     (k + 1),
                .STARVE_MAX (3)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .stall     (stall),
                .if_req    (if_req),
                .if_addr   (if_addr),
                .if_gnt    (if_gnt[k]),
                .if_rvalid (if_rvalid[k]),
                .if_rdata  (if_rdata[k]),
                .d_req     (d_req),
                .d_we      (d_we),
                .d_addr    (d_addr),
                .d_wdata   (d_wdata),
                .d_gnt     (d_gnt[k]),
                .d_rvalid  (d_rvalid[k]),
                .d_rdata   (d_rdata[k]),
                .mem_en    (mem_en[k]),
                .mem_we    (mem_we[k]),
                .mem_addr  (mem_addr[k]),
                .mem_wdata (mem_wdata[k]),
                .mem_rdata (mem_rdata[k]),
                .busy      (busy[k])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                          input logic [15:0] da, input logic [31:0] dw, input logic st);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dw;
        stall   = st;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        exp_d = 8'b0111_0111;

        reset = 1'b1;
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        repeat (2) next();

        // reset with both requests pending: no grants, bus idle
        set_in(1, 16'h0010, 1, 0, 16'h0100, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("rst_if_gnt",    64'(if_gnt[0]),    64'd0);
        chk("rst_d_gnt",     64'(d_gnt[0]),     64'd0);
        chk("rst_mem_en",    64'(mem_en[0]),    64'd0);
        chk("rst_mem_addr",  64'(mem_addr[0]),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata[0]), 64'd0);
        chk("rst_busy",      64'(busy[0]),      64'd0);
        chk("rst_if_rvalid", 64'(if_rvalid[0]), 64'd0);
        chk("rst_if_rdata",  64'(if_rdata[0]),  64'd0);
        chk("rst_d_rdata",   64'(d_rdata[0]),   64'd0);
        next();
        reset = 1'b0;
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        next();

        // fetch only, RD_LAT=1
        set_in(1, 16'h0010, 0, 0, 16'h0, 32'h0, 0);
        @(negedge clk);
        chk("f_if_gnt",   64'(if_gnt[0]),   64'd1);
        chk("f_d_gnt",    64'(d_gnt[0]),    64'd0);
        chk("f_mem_en",   64'(mem_en[0]),   64'd1);
        chk("f_mem_we",   64'(mem_we[0]),   64'd0);
        chk("f_mem_addr", 64'(mem_addr[0]), 64'h0010);
        next();
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        @(negedge clk);
        chk("f_rvalid_c1", 64'(if_rvalid[0]), 64'd0);
        chk("f_busy_c1",   64'(busy[0]),      64'd1);
        next();
        @(negedge clk);
        chk("f_rvalid_c2", 64'(if_rvalid[0]), 64'd1);
        chk("f_rdata_c2",  64'(if_rdata[0]),  64'hDEADBEEF);
        chk("f_d_rvalid",  64'(d_rvalid[0]),  64'd0);
        next();
        @(negedge clk);
        chk("f_rvalid_c3", 64'(if_rvalid[0]), 64'd0);
        chk("f_rdata_hold", 64'(if_rdata[0]), 64'hDEADBEEF);
        repeat (4) next();

        // contention: D D D F D D D F
        set_in(1, 16'h0020, 1, 0, 16'h0300, 32'h0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("con_d_gnt",    64'(d_gnt[0]),    64'(exp_d[i]));
            chk("con_if_gnt",   64'(if_gnt[0]),   64'(!exp_d[i]));
            chk("con_mem_addr", 64'(mem_addr[0]), exp_d[i] ? 64'h0300 : 64'h0020);
            next();
        end
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        repeat (5) next();

        // data write: same-cycle memory write, no response
        set_in(0, 16'h0, 1, 1, 16'h0100, 32'h12345678, 0);
        @(negedge clk);
        chk("wr_d_gnt",     64'(d_gnt[0]),     64'd1);
        chk("wr_mem_en",    64'(mem_en[0]),    64'd1);
        chk("wr_mem_we",    64'(mem_we[0]),    64'd1);
        chk("wr_mem_addr",  64'(mem_addr[0]),  64'h0100);
        chk("wr_mem_wdata", 64'(mem_wdata[0]), 64'h12345678);
        next();
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_no_rvalid", 64'({d_rvalid[0], d_rvalid[1], d_rvalid[2],
                                     if_rvalid[0], if_rvalid[1], if_rvalid[2]}), 64'd0);
            chk("wr_no_busy",   64'({busy[0], busy[1], busy[2]}), 64'd0);
            next();
        end

        // interleaved reads on the RD_LAT=3 instance: F D F -> rvalid at 4,5,6
        set_in(1, 16'h0001, 0, 0, 16'h0, 32'h0, 0);
        @(negedge clk);
        chk("il_gnt0", 64'(if_gnt[2]), 64'd1);
        next();
        set_in(0, 16'h0, 1, 0, 16'h0200, 32'h0, 0);
        @(negedge clk);
        chk("il_gnt1", 64'(d_gnt[2]), 64'd1);
        next();
        set_in(1, 16'h0002, 0, 0, 16'h0, 32'h0, 0);
        @(negedge clk);
        chk("il_gnt2", 64'(if_gnt[2]), 64'd1);
        next();
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        for (int c = 3; c < 8; c++) begin
            @(negedge clk);
            chk("il_if_rvalid", 64'(if_rvalid[2]), 64'((c == 4) || (c == 6)));
            chk("il_d_rvalid",  64'(d_rvalid[2]),  64'(c == 5));
            if (c == 4) chk("il_if_rdata4", 64'(if_rdata[2]), 64'hC0DE0001);
            if (c == 5) chk("il_d_rdata5",  64'(d_rdata[2]),  64'hC0DE0200);
            if (c == 6) chk("il_if_rdata6", 64'(if_rdata[2]), 64'hC0DE0002);
            next();
        end

        // stall: counter at 2 is frozen, in-flight read still returns
        set_in(1, 16'h0030, 1, 0, 16'h0400, 32'h0, 0);
        @(negedge clk);
        chk("st_pre_d0", 64'(d_gnt[0]), 64'd1);
        next();
        @(negedge clk);
        chk("st_pre_d1", 64'(d_gnt[0]), 64'd1);
        next();
        stall = 1'b1;
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            chk("st_no_gnt", 64'({if_gnt[0], d_gnt[0]}), 64'd0);
            chk("st_mem_en", 64'(mem_en[0]), 64'd0);
            chk("st_d_rvalid", 64'(d_rvalid[0]), 64'(c != 4));
            if (c == 3) chk("st_d_rdata", 64'(d_rdata[0]), 64'hC0DE0400);
            next();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("st_post_d", 64'(d_gnt[0]), 64'd1);
        next();
        @(negedge clk);
        chk("st_post_f",    64'(if_gnt[0]),   64'd1);
        chk("st_post_addr", 64'(mem_addr[0]), 64'h0030);
        next();
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        repeat (5) next();

        // reset mid-read on the RD_LAT=2 instance
        set_in(0, 16'h0, 1, 0, 16'h0500, 32'h0, 0);
        @(negedge clk);
        chk("rr_d_gnt", 64'(d_gnt[1]), 64'd1);
        next();
        reset = 1'b1;
        set_in(0, 16'h0, 0, 0, 16'h0, 32'h0, 0);
        @(negedge clk);
        chk("rr_busy_in_rst", 64'(busy[1]), 64'd1);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("rr_busy",    64'(busy[1]),     64'd0);
        chk("rr_if_rdata", 64'(if_rdata[1]), 64'd0);
        chk("rr_d_rdata", 64'(d_rdata[1]),  64'd0);
        for (int c = 2; c < 6; c++) begin
            chk("rr_no_rvalid", 64'(d_rvalid[1]), 64'd0);
            next();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
